// File: rtl/new_mux_pkg.sv
// Shared constants and helpers for the new_mux select tree.
package new_mux_pkg;

  localparam int unsigned M_MIN = 1;
  localparam int unsigned M_MAX = 6;

  // 2**k as an unsigned integer.
  function automatic int unsigned pow2(input int unsigned k);
    return 32'(1) << k;
  endfunction

  // Offset of tree level lvl in a flat node vector: leaves (level 0) sit at 0,
  // and each following level holds half as many nodes as the one before it.
  function automatic int unsigned level_off(input int unsigned n, input int unsigned lvl);
    return (2 * n) - ((2 * n) >> lvl);
  endfunction

endpackage

// File: rtl/new_mux_if.sv
// Select/data/result bundle for new_mux.
interface new_mux_if
  import new_mux_pkg::*;
#(
  parameter int unsigned m = 3
);

  localparam int unsigned N = pow2(m);

  logic [m-1:0] select;
  logic [N-1:0] in;
  logic         out;

  modport master (output select, output in, input out);
  modport slave  (input select, input in, output out);

endinterface

// File: rtl/new_mux_mux2.sv
// Single 2:1 multiplexer cell, purely combinational.
module new_mux_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Ternary keeps the unselected leg from leaking X into y.
  assign y = s ? b : a;

endmodule

// File: rtl/new_mux.sv
// 2**m-to-1 single-bit multiplexer built as a binary mux2 tree, registered output.
module new_mux
  import new_mux_pkg::*;
#(
  parameter int unsigned m = 3
) (
  input  logic        clk,
  input  logic        rst,
  new_mux_if.slave    bus
);

  localparam int unsigned N     = pow2(m);
  localparam int unsigned NODES = (2 * N) - 1;

  if ((m < M_MIN) || (m > M_MAX)) begin : g_bad_m
    $error("new_mux: m out of legal range");
  end

  // Flat node vector: leaves first, then every tree level in turn, root last.
  logic [NODES-1:0] node;
  logic             sel_bit;

  assign node[N-1:0] = bus.in;

  // Level lvl is steered by select[lvl] and halves the node count.
  for (genvar lvl = 0; lvl < m; lvl++) begin : g_level
    localparam int unsigned SRC   = level_off(N, lvl);
    localparam int unsigned DST   = level_off(N, lvl + 1);
    localparam int unsigned COUNT = N >> (lvl + 1);
    for (genvar j = 0; j < COUNT; j++) begin : g_node
      new_mux_mux2 u_mux2 (
        .a (node[SRC + (2 * j)]),
        .b (node[SRC + (2 * j) + 1]),
        .s (bus.select[lvl]),
        .y (node[DST + j])
      );
    end
  end

  assign sel_bit = node[NODES-1];

  // Output register; reset clears it immediately and drops any in-flight sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out <= 1'b0;
    end else begin
      bus.out <= sel_bit;
    end
  end

endmodule

// File: tb/tb_new_mux.sv
// Directed bench for new_mux at m = 3, with corner instances at m = 1 and m = 5.
`timescale 1ns/1ps
module tb_new_mux;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  new_mux_if #(.m(3)) bus3 ();
  new_mux_if #(.m(1)) bus1 ();
  new_mux_if #(.m(5)) bus5 ();

  new_mux #(.m(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  new_mux #(.m(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  new_mux #(.m(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus3.select = '0;
    bus3.in     = '1;
    bus1.select = '0;
    bus1.in     = '1;
    bus5.select = '0;
    bus5.in     = '1;
    #1;
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL reset_m3_pre_edge: out=%b expected=0", bus3.out);
    end
    step();
    step();
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL reset_m3_held: out=%b expected=0", bus3.out);
    end
    checks++;
    if (bus1.out !== 1'b0 || bus5.out !== 1'b0) begin
      errors++;
      $display("FAIL reset_corners_held: out1=%b out5=%b expected=0", bus1.out, bus5.out);
    end
    #2;
    rst = 1'b0;
    // select 0 with all-ones input: first edge after release loads 1.
    step();
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_load: out=%b expected=1", bus3.out);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] v;
    logic       exp;
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 256; d++) begin
        v           = 8'(d);
        exp         = v[s];
        bus3.select = 3'(s);
        bus3.in     = v;
        step();
        checks++;
        if (bus3.out !== exp) begin
          errors++;
          $display("FAIL sweep sel=%0d in=%h: out=%b expected=%b", s, v, bus3.out, exp);
        end
      end
    end
  endtask

  task automatic test_one_hot();
    bus3.select = 3'b101;
    bus3.in     = 8'b0010_0000;
    step();
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL one_hot_set: out=%b expected=1", bus3.out);
    end
    bus3.in = 8'b1101_1111;
    step();
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL one_hot_clear: out=%b expected=0", bus3.out);
    end
  endtask

  task automatic test_latency();
    bus3.select = 3'd0;
    bus3.in     = 8'h01;
    step();
    bus3.in = 8'h00;
    #2;
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL latency_cycle_n1: out=%b expected=1", bus3.out);
    end
    step();
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle_n2: out=%b expected=0", bus3.out);
    end
  endtask

  task automatic test_x_isolation();
    bus3.select = 3'd2;
    bus3.in     = 8'bxxxx_x1xx;
    step();
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL x_unselected_one: out=%b expected=1", bus3.out);
    end
    bus3.in = 8'bxxxx_x0xx;
    step();
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL x_unselected_zero: out=%b expected=0", bus3.out);
    end
  endtask

  task automatic test_async_reset();
    bus3.select = 3'd7;
    bus3.in     = 8'h80;
    step();
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: out=%b expected=1", bus3.out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus3.out !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: out=%b expected=0", bus3.out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus3.out !== 1'b0) begin
        errors++;
        $display("FAIL areset_hold edge=%0d: out=%b expected=0", i, bus3.out);
      end
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (bus3.out !== 1'b1) begin
      errors++;
      $display("FAIL areset_release: out=%b expected=1", bus3.out);
    end
  endtask

  task automatic test_param_corners();
    bus1.select = 1'b1;
    bus1.in     = 2'b10;
    bus5.select = 5'd31;
    bus5.in     = 32'h8000_0000;
    step();
    checks++;
    if (bus1.out !== 1'b1) begin
      errors++;
      $display("FAIL m1_sel1: out=%b expected=1", bus1.out);
    end
    checks++;
    if (bus5.out !== 1'b1) begin
      errors++;
      $display("FAIL m5_sel31: out=%b expected=1", bus5.out);
    end
    bus1.select = 1'b0;
    bus5.select = 5'd30;
    step();
    checks++;
    if (bus1.out !== 1'b0) begin
      errors++;
      $display("FAIL m1_sel0: out=%b expected=0", bus1.out);
    end
    checks++;
    if (bus5.out !== 1'b0) begin
      errors++;
      $display("FAIL m5_sel30: out=%b expected=0", bus5.out);
    end
    bus5.select = 5'd0;
    bus5.in     = 32'h0000_0001;
    step();
    checks++;
    if (bus5.out !== 1'b1) begin
      errors++;
      $display("FAIL m5_sel0: out=%b expected=1", bus5.out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_exhaustive();
    test_one_hot();
    test_latency();
    test_x_isolation();
    test_async_reset();
    test_param_corners();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
